seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl.sv | 143 ++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Serial sequence-detector controller: shifts a word LSB first into an external
// Mealy detector, registers the detector state and records where it fired.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; W held at 1 so the detector sees a flush
//   S_SHIFT | one bit per cycle driven on W; busy=1
//   S_DONE  | one-cycle done pulse, then back to S_IDLE
module seq_detect_ctrl #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [WORD_W-1:0]       data_in,
   input  logic [$clog2(WORD_W):0] nbits,
   input  logic                    next_y0,
   input  logic                    next_y1,
   input  logic                    Zout,
   output logic                    W,
   output logic                    _W,
   output logic                    y0,
   output logic                    _y0,
   output logic                    y1,
   output logic                    _y1,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic [CNT_W-1:0]        hit_cnt,
   output logic [WORD_W-1:0]       hit_map
);

   localparam int NB_W = $clog2(WORD_W) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WORD_W-1:0] r_shift;
   logic [NB_W-1:0]   r_nbits;
   logic [NB_W-1:0]   r_idx;
   logic              r_y0;
   logic              r_y1;
   logic              r_aborted;
   logic [CNT_W-1:0]  r_hit_cnt;
   logic [WORD_W-1:0] r_hit_map;
   logic              w_nbits_ok;
   logic              w_last;

   // A zero-length or over-long request completes immediately without shifting.
   assign w_nbits_ok = (nbits != '0) && (nbits <= NB_W'(WORD_W));
   assign w_last     = (r_idx == (r_nbits - NB_W'(1)));

   // Outside SHIFT the detector is fed a 1 so it flushes back to its start state.
   assign W       = (r_state == S_SHIFT) ? r_shift[0] : 1'b1;
   assign _W      = ~W;
   assign y0      = r_y0;
   assign _y0     = ~r_y0;
   assign y1      = r_y1;
   assign _y1     = ~r_y1;
   assign busy    = (r_state == S_SHIFT);
   assign done    = (r_state == S_DONE);
   assign aborted = r_aborted;
   assign hit_cnt = r_hit_cnt;
   assign hit_map = r_hit_map;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; abort wins over completion on the last bit.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = w_nbits_ok ? S_SHIFT : S_DONE;
         end
         S_SHIFT: begin
            if (abort)       w_state_nxt = S_IDLE;
            else if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Shift register, detector state, hit bookkeeping and the abort pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_nbits   <= '0;
         r_idx     <= '0;
         r_y0      <= 1'b0;
         r_y1      <= 1'b0;
         r_aborted <= 1'b0;
         r_hit_cnt <= '0;
         r_hit_map <= '0;
      end else begin
         r_aborted <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_hit_cnt <= '0;
                  r_hit_map <= '0;
                  if (w_nbits_ok) begin
                     r_shift <= data_in;
                     r_nbits <= nbits;
                     r_idx   <= '0;
                     r_y0    <= 1'b0;
                     r_y1    <= 1'b0;
                  end
               end
            end
            S_SHIFT: begin
               if (abort) begin
                  r_y0      <= 1'b0;
                  r_y1      <= 1'b0;
                  r_aborted <= 1'b1;
               end else begin
                  r_y0    <= next_y0;
                  r_y1    <= next_y1;
                  r_shift <= r_shift >> 1;
                  r_idx   <= r_idx + NB_W'(1);
                  if (Zout) begin
                     if (r_hit_cnt != {CNT_W{1'b1}}) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                     r_hit_map <= r_hit_map | (WORD_W'(1) << r_idx);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: a "four zeros in a row" detector drives the
// feedback inputs, and a word-level model predicts every output cycle by cycle.
module tb_seq_detect_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] data_in;
   logic [3:0] nbits;
   logic       next_y0, next_y1, Zout;
   logic       W, _W, y0, _y0, y1, _y1;
   logic       busy, done, aborted;
   logic [3:0] hit_cnt;
   logic [7:0] hit_map;

   seq_detect_ctrl #(.WORD_W(8), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .data_in(data_in), .nbits(nbits),
      .next_y0(next_y0), .next_y1(next_y1), .Zout(Zout),
      .W(W), ._W(_W), .y0(y0), ._y0(_y0), .y1(y1), ._y1(_y1),
      .busy(busy), .done(done), .aborted(aborted),
      .hit_cnt(hit_cnt), .hit_map(hit_map)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External detector: y counts consecutive zeros mod 4, fires on the 4th zero.
   always_comb begin
      Zout = ({y1, y0} == 2'd3) && !W;
      {next_y1, next_y0} = W ? 2'b00 : ({y1, y0} + 2'd1);
   end

   typedef struct {
      logic       busy;
      logic       done;
      logic       aborted;
      logic       w;
      logic [1:0] y;
      logic [3:0] cnt;
      logic [7:0] map;
   } exp_t;

   exp_t       exp_cur;
   bit         exp_valid;
   int         n_total, n_pass;
   int         busy_cnt, done_cnt, ab_cnt;
   logic [7:0] m_data;
   int         m_n, m_i, m_zrun, m_hits;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
   endtask

   // Per-cycle compare against the model, plus complement consistency.
   always @(negedge clk) begin
      if (rst_n) begin
         check("W_compl",  {31'd0, _W},  {31'd0, ~W});
         check("y0_compl", {31'd0, _y0}, {31'd0, ~y0});
         check("y1_compl", {31'd0, _y1}, {31'd0, ~y1});
         if (exp_valid) begin
            check("busy",    {31'd0, busy},    {31'd0, exp_cur.busy});
            check("done",    {31'd0, done},    {31'd0, exp_cur.done});
            check("aborted", {31'd0, aborted}, {31'd0, exp_cur.aborted});
            check("W",       {31'd0, W},       {31'd0, exp_cur.w});
            check("y",       {30'd0, y1, y0},  {30'd0, exp_cur.y});
            check("hit_cnt", {28'd0, hit_cnt}, {28'd0, exp_cur.cnt});
            check("hit_map", {24'd0, hit_map}, {24'd0, exp_cur.map});
         end
         if (busy)    busy_cnt++;
         if (done)    done_cnt++;
         if (aborted) ab_cnt++;
      end
   end

   // Drive one cycle of inputs and predict the outputs after the coming edge.
   task automatic step(input logic st, input logic ab, input logic [7:0] d, input logic [3:0] nb);
      exp_t e;
      @(negedge clk);
      #1;
      start = st; abort = ab; data_in = d; nbits = nb;
      e = exp_cur;
      e.busy = 1'b0; e.done = 1'b0; e.aborted = 1'b0; e.w = 1'b1;
      if (exp_cur.busy) begin
         if (ab) begin
            e.aborted = 1'b1;
            e.y = 2'd0;
         end else begin
            if (m_data[m_i] == 1'b0) begin
               m_zrun++;
               if (m_zrun % 4 == 0) begin
                  m_hits++;
                  e.map[m_i] = 1'b1;
               end
            end else begin
               m_zrun = 0;
            end
            e.y   = 2'(m_zrun % 4);
            e.cnt = (m_hits > 15) ? 4'd15 : 4'(m_hits);
            m_i++;
            if (m_i == m_n) e.done = 1'b1;
            else begin
               e.busy = 1'b1;
               e.w    = m_data[m_i];
            end
         end
      end else if (!exp_cur.done && st) begin
         e.cnt = 4'd0;
         e.map = 8'd0;
         if (nb >= 4'd1 && nb <= 4'd8) begin
            m_data = d; m_n = int'(nb); m_i = 0; m_zrun = 0; m_hits = 0;
            e.y    = 2'd0;
            e.busy = 1'b1;
            e.w    = d[0];
         end else begin
            e.done = 1'b1;
         end
      end
      exp_cur = e;
   endtask

   // One word: start, optional abort / stray start at SHIFT cycle index, run to idle.
   task automatic run_word(input logic [7:0] d, input logic [3:0] nb, input int ab_at, input int st_at);
      int k;
      busy_cnt = 0; done_cnt = 0; ab_cnt = 0;
      step(1'b1, 1'b0, d, nb);
      k = 0;
      while ((exp_cur.busy || exp_cur.done) && k < 40) begin
         step(k == st_at, k == ab_at, (k == st_at) ? 8'hFF : d, (k == st_at) ? 4'd1 : nb);
         k++;
      end
      step(1'b0, 1'b0, 8'h00, 4'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},  {31'd0, busy},    32'd0);
      check({tag, "_done"},  {31'd0, done},    32'd0);
      check({tag, "_abort"}, {31'd0, aborted}, 32'd0);
      check({tag, "_W"},     {30'd0, W, _W},   32'd2);
      check({tag, "_y"},     {28'd0, y1, _y1, y0, _y0}, 32'd5);
      check({tag, "_cnt"},   {28'd0, hit_cnt}, 32'd0);
      check({tag, "_map"},   {24'd0, hit_map}, 32'd0);
   endtask

   task automatic reset_model();
      exp_cur.busy = 1'b0; exp_cur.done = 1'b0; exp_cur.aborted = 1'b0;
      exp_cur.w = 1'b1; exp_cur.y = 2'd0; exp_cur.cnt = 4'd0; exp_cur.map = 8'd0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total = 0; n_pass = 0;
      exp_valid = 0;
      start = 0; abort = 0; data_in = 0; nbits = 0;
      rst_n = 0;
      reset_model();
      #3;
      check_reset_vals("por");
      @(negedge clk); #1;
      rst_n = 1;
      exp_valid = 1;

      // Directed words with hand-computed results.
      run_word(8'h00, 4'd8, -1, -1); #1;
      check("w00_busy", busy_cnt, 32'd8);
      check("w00_done", done_cnt, 32'd1);
      check("w00_cnt",  {28'd0, hit_cnt}, 32'd2);
      check("w00_map",  {24'd0, hit_map}, 32'h88);

      run_word(8'h10, 4'd8, -1, -1); #1;
      check("w10_cnt", {28'd0, hit_cnt}, 32'd1);
      check("w10_map", {24'd0, hit_map}, 32'h08);

      run_word(8'hFF, 4'd8, -1, -1); #1;
      check("wFF_cnt", {28'd0, hit_cnt}, 32'd0);
      check("wFF_map", {24'd0, hit_map}, 32'h00);

      run_word(8'h00, 4'd7, -1, -1); #1;
      check("n7_busy", busy_cnt, 32'd7);
      check("n7_cnt",  {28'd0, hit_cnt}, 32'd1);
      check("n7_map",  {24'd0, hit_map}, 32'h08);

      run_word(8'h00, 4'd0, -1, -1); #1;
      check("n0_busy", busy_cnt, 32'd0);
      check("n0_done", done_cnt, 32'd1);
      check("n0_cnt",  {28'd0, hit_cnt}, 32'd0);

      run_word(8'h00, 4'd9, -1, -1); #1;
      check("n9_busy", busy_cnt, 32'd0);
      check("n9_done", done_cnt, 32'd1);

      run_word(8'h00, 4'd8, -1, 2); #1;
      check("stray_busy", busy_cnt, 32'd8);
      check("stray_cnt",  {28'd0, hit_cnt}, 32'd2);
      check("stray_map",  {24'd0, hit_map}, 32'h88);

      run_word(8'h00, 4'd8, 4, -1); #1;
      check("ab_pulse", ab_cnt,   32'd1);
      check("ab_done",  done_cnt, 32'd0);
      check("ab_cnt",   {28'd0, hit_cnt}, 32'd1);
      check("ab_map",   {24'd0, hit_map}, 32'h08);
      check("ab_W",     {31'd0, W},       32'd1);

      run_word(8'h00, 4'd8, 7, -1); #1;
      check("ablast_pulse", ab_cnt,   32'd1);
      check("ablast_done",  done_cnt, 32'd0);

      // Reset in the middle of a word, between clock edges.
      busy_cnt = 0; done_cnt = 0; ab_cnt = 0;
      step(1'b1, 1'b0, 8'h00, 4'd8);
      for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 8'h00, 4'd8);
      @(posedge clk); #2;
      exp_valid = 0;
      rst_n = 0;
      #1;
      check_reset_vals("mid");
      @(negedge clk); #1;
      rst_n = 1;
      reset_model();
      exp_valid = 1;
      check("mid_no_done",  done_cnt, 32'd0);
      check("mid_no_abort", ab_cnt,   32'd0);
      run_word(8'h00, 4'd8, -1, -1); #1;
      check("post_rst_busy", busy_cnt, 32'd8);
      check("post_rst_cnt",  {28'd0, hit_cnt}, 32'd2);
      check("post_rst_map",  {24'd0, hit_map}, 32'h88);

      // Randomised words, gaps with stray aborts, mid-word aborts and starts.
      for (int t = 0; t < 60; t++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 8'h00, 4'd0);
         run_word(8'($urandom & $urandom), 4'($urandom_range(0, 10)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
      end
      step(1'b0, 1'b0, 8'h00, 4'd0);
      step(1'b0, 1'b0, 8'h00, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
